alu_4bit: RTL and testbench

- 4-bit registered arithmetic/logic unit driven by a 3-bit opcode and two 4-bit operands.
- Result and status flags are computed combinationally and captured on each rising clock edge. Outputs are stable for one full cycle.
- Sits in the datapath as a single-cycle execute stage. There is no handshake: a new operation is accepted every cycle.

---
 rtl/alu_4bit.sv | 99 +++++++++
 tb/tb_alu_4bit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// 4-bit registered ALU: eight operations selected by OPCODE, result and flags captured every clock.
// Optional build macro ALU_SAT_EN makes ADD/SUB saturate as signed two's-complement.
module alu_4bit (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] OPCODE,
    input  logic [3:0] OP1,
    input  logic [3:0] OP2,
    output logic [3:0] RESULT,
    output logic       CARRY,
    output logic       ZERO,
    output logic       NEG,
    output logic       OVF
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

    opcode_e    op;
    logic [4:0] sum5;
    logic [4:0] diff5;
    logic [3:0] res_raw;
    logic [3:0] res_fin;
    logic       carry_nxt;
    logic       ovf_nxt;

    assign op    = opcode_e'(OPCODE);
    assign sum5  = {1'b0, OP1} + {1'b0, OP2};
    // Bit 4 of the widened difference is the unsigned borrow (OP1 < OP2).
    assign diff5 = {1'b0, OP1} - {1'b0, OP2};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        res_raw   = 4'h0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_raw   = sum5[3:0];
                carry_nxt = sum5[4];
                ovf_nxt   = (OP1[3] == OP2[3]) && (sum5[3] != OP1[3]);
            end
            OP_SUB: begin
                res_raw   = diff5[3:0];
                carry_nxt = diff5[4];
                ovf_nxt   = (OP1[3] != OP2[3]) && (diff5[3] != OP1[3]);
            end
            OP_AND: res_raw = OP1 & OP2;
            OP_OR:  res_raw = OP1 | OP2;
            OP_XOR: res_raw = OP1 ^ OP2;
            OP_NOT: res_raw = ~OP1;
            OP_SHL: begin
                res_raw   = {OP1[2:0], 1'b0};
                carry_nxt = OP1[3];
            end
            OP_SHR: begin
                res_raw   = {1'b0, OP1[3:1]};
                carry_nxt = OP1[0];
            end
        endcase
    end

`ifdef ALU_SAT_EN
    // Clamp toward the sign of A; the flags keep reporting the unsaturated condition.
    always_comb begin
        res_fin = res_raw;
        if (((op == OP_ADD) || (op == OP_SUB)) && ovf_nxt)
            res_fin = OP1[3] ? 4'b1000 : 4'b0111;
    end
`else
    assign res_fin = res_raw;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RESULT <= 4'h0;
            CARRY  <= 1'b0;
            ZERO   <= 1'b0;
            NEG    <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            RESULT <= res_fin;
            CARRY  <= carry_nxt;
            ZERO   <= (res_fin == 4'h0);
            NEG    <= res_fin[3];
            OVF    <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: the driver queues hand-computed responses, a monitor pops and compares each cycle.
// Expected values switch with ALU_SAT_EN where saturation changes the ADD/SUB result.
module tb_alu_4bit;

    logic       clk;
    logic       rstn;
    logic [2:0] OPCODE;
    logic [3:0] OP1;
    logic [3:0] OP2;
    logic [3:0] RESULT;
    logic       CARRY;
    logic       ZERO;
    logic       NEG;
    logic       OVF;

    int checks = 0;
    int errors = 0;

    // Packed {RESULT, CARRY, ZERO, NEG, OVF}
    logic [7:0] exp_q[$];
    string      name_q[$];

    alu_4bit dut (
        .clk    (clk),
        .rstn   (rstn),
        .OPCODE (OPCODE),
        .OP1    (OP1),
        .OP2    (OP2),
        .RESULT (RESULT),
        .CARRY  (CARRY),
        .ZERO   (ZERO),
        .NEG    (NEG),
        .OVF    (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pk(input logic [3:0] r, input logic c, input logic z,
                                      input logic n, input logic o);
        return {r, c, z, n, o};
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got R=%h C%b Z%b N%b V%b, want R=%h C%b Z%b N%b V%b", name,
                     actual[7:4], actual[3], actual[2], actual[1], actual[0],
                     expected[7:4], expected[3], expected[2], expected[1], expected[0]);
        end
    endtask

    // Drive one operation at the falling edge and queue its response for the next rising edge.
    task automatic issue(input string name, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] expected);
        @(negedge clk);
        OPCODE = op;
        OP1    = a;
        OP2    = b;
        exp_q.push_back(expected);
        name_q.push_back(name);
    endtask

    // Monitor: outputs are valid every cycle out of reset, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rstn && (exp_q.size() > 0))
                check(name_q.pop_front(), {RESULT, CARRY, ZERO, NEG, OVF}, exp_q.pop_front());
        end
    end

    initial begin
        int budget;
        rstn   = 1'b0;
        OPCODE = 3'b000;
        OP1    = 4'hF;
        OP2    = 4'h1;

        // Reset held across several clock edges
        repeat (3) @(posedge clk);
        #1 check("reset_hold", {RESULT, CARRY, ZERO, NEG, OVF}, 8'h00);
        @(negedge clk);
        check("reset_hold_neg", {RESULT, CARRY, ZERO, NEG, OVF}, 8'h00);
        // Release: the pending ADD F+1 is the first operation
        rstn = 1'b1;
        exp_q.push_back(pk(4'h0, 1'b1, 1'b1, 1'b0, 1'b0));
        name_q.push_back("release_add_f_1");

        issue("and_zero", 3'b010, 4'h0, 4'h0, pk(4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef ALU_SAT_EN
        issue("add_7_1",  3'b000, 4'h7, 4'h1, pk(4'h7, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        issue("add_7_1",  3'b000, 4'h7, 4'h1, pk(4'h8, 1'b0, 1'b0, 1'b1, 1'b1));
`endif
        issue("sub_2_5",  3'b001, 4'h2, 4'h5, pk(4'hD, 1'b1, 1'b0, 1'b1, 1'b0));
        issue("sub_5_5",  3'b001, 4'h5, 4'h5, pk(4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("shl_1001", 3'b110, 4'h9, 4'h0, pk(4'h2, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("shr_0011", 3'b111, 4'h3, 4'hF, pk(4'h1, 1'b1, 1'b0, 1'b0, 1'b0));
        issue("add_f_1",  3'b000, 4'hF, 4'h1, pk(4'h0, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef ALU_SAT_EN
        issue("add_8_8",  3'b000, 4'h8, 4'h8, pk(4'h8, 1'b1, 1'b0, 1'b1, 1'b1));
        issue("sub_8_1",  3'b001, 4'h8, 4'h1, pk(4'h8, 1'b0, 1'b0, 1'b1, 1'b1));
        issue("sub_7_f",  3'b001, 4'h7, 4'hF, pk(4'h7, 1'b1, 1'b0, 1'b0, 1'b1));
`else
        issue("add_8_8",  3'b000, 4'h8, 4'h8, pk(4'h0, 1'b1, 1'b1, 1'b0, 1'b1));
        issue("sub_8_1",  3'b001, 4'h8, 4'h1, pk(4'h7, 1'b0, 1'b0, 1'b0, 1'b1));
        issue("sub_7_f",  3'b001, 4'h7, 4'hF, pk(4'h8, 1'b1, 1'b0, 1'b1, 1'b1));
`endif
        issue("add_3_4",  3'b000, 4'h3, 4'h4, pk(4'h7, 1'b0, 1'b0, 1'b0, 1'b0));
        issue("or_5_a",   3'b011, 4'h5, 4'hA, pk(4'hF, 1'b0, 1'b0, 1'b1, 1'b0));
        issue("xor_6_6",  3'b100, 4'h6, 4'h6, pk(4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("xor_a_5",  3'b100, 4'hA, 4'h5, pk(4'hF, 1'b0, 1'b0, 1'b1, 1'b0));
        issue("not_5",    3'b101, 4'h5, 4'h3, pk(4'hA, 1'b0, 1'b0, 1'b1, 1'b0));
        issue("not_f",    3'b101, 4'hF, 4'h0, pk(4'h0, 1'b0, 1'b1, 1'b0, 1'b0));
        issue("shl_0111", 3'b110, 4'h7, 4'h0, pk(4'hE, 1'b0, 1'b0, 1'b1, 1'b0));
        issue("shr_1000", 3'b111, 4'h8, 4'h0, pk(4'h4, 1'b0, 1'b0, 1'b0, 1'b0));

        // Back-to-back ADDs with an asynchronous reset pulse between edges
        issue("add_1_2",  3'b000, 4'h1, 4'h2, pk(4'h3, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check("async_reset_clear", {RESULT, CARRY, ZERO, NEG, OVF}, 8'h00);
        #1 rstn = 1'b1;
        check("after_release_no_edge", {RESULT, CARRY, ZERO, NEG, OVF}, 8'h00);
`ifdef ALU_SAT_EN
        issue("add_4_4_resume", 3'b000, 4'h4, 4'h4, pk(4'h7, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        issue("add_4_4_resume", 3'b000, 4'h4, 4'h4, pk(4'h8, 1'b0, 1'b0, 1'b1, 1'b1));
`endif
        issue("add_2_3",  3'b000, 4'h2, 4'h3, pk(4'h5, 1'b0, 1'b0, 1'b0, 1'b0));

        // Let the monitor drain the scoreboard within a bounded number of cycles
        budget = 0;
        while ((exp_q.size() > 0) && (budget < 20)) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses never compared, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
